// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the iterative multiply sequencer.
// Also imported by the main controller to decode the busy stall.
package mul_seq_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITER  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } mul_state_e;

  function automatic logic mul_busy(
    input mul_state_e s
  );
    return (s == RUN) || (s == FINISH);
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational conditional two's-complement negate.
// Used for operand magnitudes and the final product sign.
module mul_sign_fix #(
  parameter int W = 64
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiply sequencer for MUL/UMULL/SMULL.
// Optional early termination: define MUL_EARLY_TERM_EN.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_long,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e st;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             sign;
  logic             long_q;

  logic             do_signed;
  logic             a_neg;
  logic             b_neg;
  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_add;
  logic [PW-1:0]    acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic [PW-1:0]    product;
  logic             last_iter;

  assign do_signed = is_long & is_signed;
  assign a_neg     = do_signed & op_a[WIDTH-1];
  assign b_neg     = do_signed & op_b[WIDTH-1];
  assign accept    = start & ((st == IDLE) | (st == DONE));

  // 0x80000000 negates to itself, which is the right unsigned magnitude
  mul_sign_fix #(.W(WIDTH)) u_mag_a (
    .value  (op_a),
    .negate (a_neg),
    .result (a_mag)
  );

  mul_sign_fix #(.W(WIDTH)) u_mag_b (
    .value  (op_b),
    .negate (b_neg),
    .result (b_mag)
  );

  mul_sign_fix #(.W(PW)) u_prod (
    .value  (acc),
    .negate (sign),
    .result (product)
  );

  assign acc_add     = mplier[0] ? mcand : '0;
  assign acc_next    = acc + acc_add;
  assign mplier_next = mplier >> 1;

`ifdef MUL_EARLY_TERM_EN
  assign last_iter = (count == LAST) || (mplier_next == '0);
`else
  assign last_iter = (count == LAST);
`endif

  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      count     <= '0;
      sign      <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
        count  <= '0;
        sign   <= a_neg ^ b_neg;
        long_q <= is_long;
      end
      unique case (st)
        IDLE: begin
          if (start) begin
            st   <= RUN;
            busy <= 1'b1;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          count  <= count + CW'(1);
          if (last_iter) begin
            st <= FINISH;
          end
        end
        FINISH: begin
          result_lo <= product[WIDTH-1:0];
          result_hi <= long_q ? product[PW-1:WIDTH] : '0;
          st        <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        DONE: begin
          if (start) begin
            st   <= RUN;
            busy <= 1'b1;
          end else begin
            st <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: random and directed multiplies
// checked against plain 64-bit arithmetic.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_long = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [1:0]  state;

  mul_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_long   (is_long),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          st;
    int          lat;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  function automatic exp_t model(logic lng, logic sgn,
                                 logic [31:0] a, logic [31:0] b,
                                 int st);
    exp_t e;
    logic [63:0] p;
    longint sa, sb;
    logic [31:0] mb;
    int bl;
    if (lng && sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p = 64'(sa * sb);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    e.lo = p[31:0];
    e.hi = lng ? p[63:32] : 32'h0;
    e.st = st;
    mb = (lng && sgn && b[31]) ? (32'h0 - b) : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) bl = i + 1;
    if (bl == 0) bl = 1;
`ifdef MUL_EARLY_TERM_EN
    e.lat = bl + 1;
`else
    e.lat = 33;
`endif
    return e;
  endfunction

  // Monitor: busy/done timing and results against the queue head.
  always @(negedge clk) begin : mon
    logic eb, ed;
    int d;
    if (!reset) begin
      eb = 1'b0;
      ed = 1'b0;
      if (q.size() > 0 && cyc >= q[0].st) begin
        d = cyc - q[0].st;
        eb = (d < q[0].lat);
        ed = (d == q[0].lat);
      end
      check("busy", {63'b0, busy}, {63'b0, eb});
      check("done", {63'b0, done}, {63'b0, ed});
      if (ed) begin
        check("result_lo", {32'b0, result_lo}, {32'b0, q[0].lo});
        check("result_hi", {32'b0, result_hi}, {32'b0, q[0].hi});
        check("state_done", {62'b0, state}, 64'd3);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(logic lng, logic sgn, logic [31:0] a, logic [31:0] b);
    start = 1'b1;
    is_long = lng;
    is_signed = sgn;
    op_a = a;
    op_b = b;
    q.push_back(model(lng, sgn, a, b, cyc + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    is_long = 1'($urandom);
    is_signed = 1'($urandom);
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {62'b0, state}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_lo", {32'b0, result_lo}, 64'd0);
    check("rst_hi", {32'b0, result_hi}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    issue(1'b0, 1'b0, 32'd7, 32'd6);
    wait_done();
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2);
    wait_done();
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done();

    for (int t = 0; t < 40; t++) begin
      issue(1'($urandom), 1'($urandom), pick(), pick());
      wait_done();
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
    end

    // Mid-run start is ignored, then reset aborts without a done.
    @(posedge clk); #1;
    issue(1'b0, 1'b0, $urandom, 32'h8000_0000 | $urandom);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op_a = 32'd11;
    op_b = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    start = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check("abort_state", {62'b0, state}, 64'd0);
    check("abort_lo", {32'b0, result_lo}, 64'd0);
    check("abort_hi", {32'b0, result_hi}, 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    issue(1'b0, 1'b0, 32'd3, 32'd5);
    wait_done();

    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'd9, 32'd3);
    wait_done();
    issue(1'b0, 1'b0, 32'd0, 32'd0);
    wait_done();

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
